// File: rtl/xor_two_in.sv
// ----------------------------------------------------------------------------
// xor_two_in
//
// Registered bitwise XOR / XNOR unit for the CPU datapath. One clock after a
// valid request it presents the result together with zero, parity and
// ones-count status for the ALU flag logic.
//
// Parameters
//   width     : operand and result width in bits (1 or more)
//
// Ports
//   clk       : input  clock, all state updates on the rising edge
//   rst       : input  synchronous active-high reset (priority over in_valid)
//   in_valid  : input  operands valid, capture this edge
//   invert    : input  0 = XOR, 1 = XNOR
//   input1    : input  [width-1:0] operand A
//   input2    : input  [width-1:0] operand B
//   result    : output [width-1:0] registered (A ^ B) ^ {width{invert}}
//   out_valid : output result and flags were updated on the last edge
//   zero      : output result is all zeros
//   parity    : output XOR-reduction of result
//   ones      : output [$clog2(width+1)-1:0] population count of result
// ----------------------------------------------------------------------------
module xor_two_in #(
  parameter int width = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         invert,
  input  logic [width-1:0]             input1,
  input  logic [width-1:0]             input2,
  output logic [width-1:0]             result,
  output logic                         out_valid,
  output logic                         zero,
  output logic                         parity,
  output logic [$clog2(width+1)-1:0]   ones
);

  localparam int OW = $clog2(width + 1);

  // Exact population count; the accumulator is wide enough to hold width.
  function automatic logic [OW-1:0] popcount(input logic [width-1:0] v);
    logic [OW-1:0] cnt;
    cnt = {OW{1'b0}};
    for (int i = 0; i < width; i++) begin
      cnt = cnt + OW'(v[i]);
    end
    return cnt;
  endfunction

  // Odd-parity of a result word.
  function automatic logic parity_of(input logic [width-1:0] v);
    return ^v;
  endfunction

  logic [width-1:0] result_q, result_d;
  logic             valid_q,  valid_d;
  logic             zero_q,   zero_d;
  logic             parity_q, parity_d;
  logic [OW-1:0]    ones_q,   ones_d;
  logic [width-1:0] op_result_s;

  // Candidate result for this edge; invert is replicated so XNOR is one XOR.
  always_comb begin
    op_result_s = (input1 ^ input2) ^ {width{invert}};
  end

  // Next-state selection: capture on a request, otherwise hold the result.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    ones_d   = ones_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      result_d = op_result_s;
      // Flags come from the same next value so they never lag the result.
      zero_d   = (op_result_s == {width{1'b0}});
      parity_d = parity_of(op_result_s);
      ones_d   = popcount(op_result_s);
      valid_d  = 1'b1;
    end else begin
      valid_d  = 1'b0;
    end
  end

  // State registers; reset leaves flags consistent with a zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= {width{1'b0}};
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      ones_q   <= {OW{1'b0}};
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      ones_q   <= ones_d;
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_xor_two_in.sv
// ----------------------------------------------------------------------------
// tb_xor_two_in
//
// Directed checks on a 32-bit instance followed by a random regression on a
// 32-bit and a 1-bit instance against a small reference model.
// ----------------------------------------------------------------------------
module tb_xor_two_in;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv32, inv32;
  logic [31:0] a32, b32;
  logic [31:0] res32;
  logic        ov32, z32, p32;
  logic [5:0]  ones32;

  logic        iv1, inv1;
  logic [0:0]  a1, b1;
  logic [0:0]  res1;
  logic        ov1, z1, p1;
  logic [0:0]  ones1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  xor_two_in #(.width(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .invert(inv32),
    .input1(a32), .input2(b32), .result(res32), .out_valid(ov32),
    .zero(z32), .parity(p32), .ones(ones32)
  );

  xor_two_in #(.width(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .invert(inv1),
    .input1(a1), .input2(b1), .result(res1), .out_valid(ov1),
    .zero(z1), .parity(p1), .ones(ones1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] r, input logic v,
                       input logic z, input logic p, input logic [5:0] n);
    chk({tag, ".result"},    res32,          r);
    chk({tag, ".out_valid"}, {31'd0, ov32},  {31'd0, v});
    chk({tag, ".zero"},      {31'd0, z32},   {31'd0, z});
    chk({tag, ".parity"},    {31'd0, p32},   {31'd0, p});
    chk({tag, ".ones"},      {26'd0, ones32}, {26'd0, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_res32;
  logic        m_ov32, m_z32, m_p32;
  logic [5:0]  m_ones32;
  logic        m_res1, m_ov1;

  initial begin
    // Reset for two cycles with a request pending; it must be discarded.
    rst = 1'b1; iv32 = 1'b1; inv32 = 1'b0; a32 = 32'hFFFF_FFFF; b32 = 32'h0;
    iv1 = 1'b0; inv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    tick();
    tick();
    chk32("reset", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);

    // Back-to-back XOR requests.
    rst = 1'b0;
    a32 = 32'h0000_0000; b32 = 32'hFFFF_FFFF; tick();
    chk32("xor0", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'd32);
    a32 = 32'hF0F0_F0F0; b32 = 32'h0F0F_0F0F; tick();
    chk32("xor1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'd32);
    a32 = 32'h0F0F_0F0F; b32 = 32'h0F0F_0F0F; tick();
    chk32("xor2", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 6'd0);
    a32 = 32'h1111_1111; b32 = 32'h3333_3333; tick();
    chk32("xor3", 32'h2222_2222, 1'b1, 1'b0, 1'b0, 6'd8);

    // Hold: idle cycles with changing operands keep the result.
    iv32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; inv32 = 1'b1; tick();
    chk32("hold0", 32'h2222_2222, 1'b0, 1'b0, 1'b0, 6'd8);
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; inv32 = 1'b0; tick();
    chk32("hold1", 32'h2222_2222, 1'b0, 1'b0, 1'b0, 6'd8);
    a32 = 32'h0; b32 = 32'h0; tick();
    chk32("hold2", 32'h2222_2222, 1'b0, 1'b0, 1'b0, 6'd8);

    // XNOR.
    iv32 = 1'b1; inv32 = 1'b1;
    a32 = 32'h0F0F_0F0F; b32 = 32'h0F0F_0F0F; tick();
    chk32("xnor0", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'd32);
    a32 = 32'h0000_0000; b32 = 32'hFFFF_FFFE; tick();
    chk32("xnor1", 32'h0000_0001, 1'b1, 1'b0, 1'b1, 6'd1);

    // Reset mid-stream discards the coincident request.
    inv32 = 1'b0; rst = 1'b1;
    a32 = 32'h1234_5678; b32 = 32'h0; tick();
    chk32("midrst", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
    rst = 1'b0; tick();
    chk32("postrst", 32'h1234_5678, 1'b1, 1'b0, 1'b1, 6'd13);

    // Random regression on both widths against the reference model.
    for (int i = 0; i < 300; i++) begin
      rst   = (i == 0) || ($urandom_range(0, 15) == 0);
      iv32  = $urandom_range(0, 1) == 1;
      inv32 = $urandom_range(0, 1) == 1;
      a32   = $urandom;
      b32   = $urandom;
      iv1   = $urandom_range(0, 1) == 1;
      inv1  = $urandom_range(0, 1) == 1;
      a1    = 1'($urandom_range(0, 1));
      b1    = 1'($urandom_range(0, 1));
      if (rst) begin
        m_res32 = 32'h0; m_ov32 = 1'b0; m_res1 = 1'b0; m_ov1 = 1'b0;
      end else begin
        m_ov32 = iv32;
        if (iv32) m_res32 = a32 ^ b32 ^ {32{inv32}};
        m_ov1 = iv1;
        if (iv1) m_res1 = a1[0] ^ b1[0] ^ inv1;
      end
      m_ones32 = 6'($countones(m_res32));
      m_z32    = (m_res32 == 32'h0);
      m_p32    = m_ones32[0];
      tick();
      chk32("rnd32", m_res32, m_ov32, m_z32, m_p32, m_ones32);
      chk("rnd32.inv_zero", {31'd0, z32}, {31'd0, (ones32 == 6'd0)});
      chk("rnd32.inv_par",  {31'd0, p32}, {31'd0, ones32[0]});
      chk("rnd1.result",    {31'd0, res1[0]}, {31'd0, m_res1});
      chk("rnd1.out_valid", {31'd0, ov1},     {31'd0, m_ov1});
      chk("rnd1.zero",      {31'd0, z1},      {31'd0, ~m_res1});
      chk("rnd1.parity",    {31'd0, p1},      {31'd0, m_res1});
      chk("rnd1.ones",      {31'd0, ones1[0]}, {31'd0, m_res1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
